// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receiver. 2-flop synchronizer, 3-sample majority vote per bit.
// Latency: data_o/valid_o update one clk_i after the stop-bit decision, at sample 9 of the stop bit.
// Backpressure: one-byte holding register; a byte completing while valid_o=1 and ready_i=0 is dropped with overrun_o.
//
// Parameters: n = data bits per frame (n >= 2), CLK_DIV = clk_i cycles per oversample tick.
// Ports: clk_i/rst_ni (sync, active-low), Rx_i serial line (idle high), ready_i downstream accept,
//        data_o/valid_o held byte, frame_err_o/overrun_o/parity_err_o one-cycle error pulses.
// Optional feature: define UART_RX_PARITY_EN for one even-parity bit after the data bits;
//        otherwise parity_err_o is constant 0.
`timescale 1ns/1ps
module uart_rx_frame #(
    parameter int n       = 8,
    parameter int CLK_DIV = 27
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         Rx_i,
    input  logic         ready_i,
    output logic [n-1:0] data_o,
    output logic         valid_o,
    output logic         frame_err_o,
    output logic         overrun_o,
    output logic         parity_err_o
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (n > 1) ? $clog2(n) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Synchronizer: flops reset to the idle level so a reset never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx_i;
            rx_sync <= rx_meta;
        end
    end

    logic start_det;
    assign start_det = (state == IDLE) && !rx_sync;

    // ------------------------------------------------------------------
    // Oversample tick. Restarting on start detection phase-aligns every
    // sample point to the falling edge of the start bit.
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            tick_cnt <= '0;
        else if (start_det || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // ------------------------------------------------------------------
    // Sample/bit counters and the majority vote over samples 7, 8, 9.
    // Samples 7 and 8 are stored; sample 9 is the live synchronized bit,
    // so the vote is ready exactly on the sample-9 tick.
    // ------------------------------------------------------------------
    logic [3:0]    samp_cnt;
    logic [BW-1:0] bit_cnt;
    logic          s7, s8, maj;
    logic          samp9, samp15;
    logic [n-1:0]  shreg;
    logic          shift_en, deliver, frame_bad, byte_ok;
`ifdef UART_RX_PARITY_EN
    logic          par_smp;
`endif

    assign maj    = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
    assign samp9  = tick && (samp_cnt == 4'd9);
    assign samp15 = tick && (samp_cnt == 4'd15);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            samp_cnt <= '0;
            bit_cnt  <= '0;
            s7       <= 1'b0;
            s8       <= 1'b0;
            shreg    <= '0;
        end else begin
            // samp_cnt wraps 15 -> 0 on its own at each bit boundary
            if (start_det)
                samp_cnt <= '0;
            else if (tick && (state != IDLE) && (state != BREAK))
                samp_cnt <= samp_cnt + 4'd1;

            if (start_det)
                bit_cnt <= '0;
            else if ((state == DATA) && samp15)
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

            if (tick && (samp_cnt == 4'd7))
                s7 <= rx_sync;
            if (tick && (samp_cnt == 4'd8))
                s8 <= rx_sync;

            // LSB arrives first, so shift in from the top
            if (shift_en)
                shreg <= {maj, shreg[n-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Parity: error is flagged at the parity sample and remembered so the
    // stop check still runs but the byte is not delivered.
    // ------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            par_bad      <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= 1'b0;
            if (start_det) begin
                par_bad <= 1'b0;
            end else if (par_smp) begin
                par_bad      <= ^{shreg, maj};
                parity_err_o <= ^{shreg, maj};
            end
        end
    end

    assign byte_ok = !par_bad;
`else
    assign parity_err_o = 1'b0;
    assign byte_ok      = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_sync)
                    state_nxt = START;
            end
            START: begin
                // a start bit that votes high was a glitch
                if (samp9 && maj)
                    state_nxt = IDLE;
                else if (samp15)
                    state_nxt = DATA;
            end
            DATA: begin
                shift_en = samp9;
                if (samp15 && (bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_smp = samp9;
                if (samp15)
                    state_nxt = STOP;
            end
`endif
            STOP: begin
                // leave at sample 9 so a back-to-back start bit is not missed
                if (samp9) begin
                    if (maj) begin
                        deliver   = byte_ok;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register and error pulses. A delivery coinciding with a
    // handshake reloads and keeps valid_o high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_bad;
            overrun_o   <= 1'b0;
            if (deliver) begin
                if (valid_o && !ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    data_o  <= shreg;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int CLK_DIV = 27;
    localparam int BIT     = 16 * CLK_DIV;   // 432 clk per bit
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid, fe, ov, pe;

    always #5 clk = ~clk;

    uart_rx_frame #(.n(8), .CLK_DIV(CLK_DIV)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .Rx_i         (rx),
        .ready_i      (ready),
        .data_o       (data),
        .valid_o      (valid),
        .frame_err_o  (fe),
        .overrun_o    (ov),
        .parity_err_o (pe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // observed activity, sampled on the falling edge
    logic [7:0] got_q[$];
    int fe_cyc = 0, ov_cyc = 0, pe_cyc = 0, v_cyc = 0, stab_err = 0;
    logic       prev_v = 1'b0, prev_hs = 1'b0;
    logic [7:0] prev_d = 8'h00;

    // reference model: bytes the consumer should take, holding buffer, error counts
    logic [7:0] exp_q[$];
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data);
            if (valid) v_cyc++;
            if (fe) fe_cyc++;
            if (ov) ov_cyc++;
            if (pe) pe_cyc++;
            if (prev_v && !prev_hs && valid && (data != prev_d)) stab_err++;
        end
        prev_v  = valid;
        prev_hs = valid && ready;
        prev_d  = data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int len);
        rx = v;
        repeat (len) begin
            @(posedge clk);
            #1;
        end
    endtask

    // frame outcome from the protocol rules: the byte survives only with a
    // high stop bit and correct parity; it then lands in an empty buffer,
    // goes straight to a ready consumer, or is lost as an overrun.
    task automatic expect_frame(input logic [7:0] d, input bit bad_par, input bit stop_ok);
        if (bad_par) exp_pe++;
        if (!stop_ok) exp_fe++;
        if (stop_ok && !bad_par) begin
            if (m_valid && !ready) begin
                exp_ov++;
            end else begin
                m_data = d;
                if (ready) exp_q.push_back(d);
                else       m_valid = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_ok, input int gap);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        if (PAR_EN) drive((^d) ^ bad_par, BIT);
        if (!stop_ok) drive(1'b0, 2000);
        drive(1'b1, BIT + gap);
    endtask

    task automatic do_frame(input logic [7:0] d, input bit bad_par, input bit stop_ok);
        send_frame(d, bad_par, stop_ok, $urandom_range(20, 200));
        expect_frame(d, bad_par, stop_ok);
    endtask

    task automatic send_glitch(input int len);
        drive(1'b0, len);
        drive(1'b1, 600);
    endtask

    task automatic set_ready(input bit v);
        ready = v;
        if (v && m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
        drive(1'b1, 4);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":n_bytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, ":byte"}, got_q[i], exp_q[i]);
        chk({tag, ":frame_err"}, fe_cyc, exp_fe);
        chk({tag, ":overrun"}, ov_cyc, exp_ov);
        chk({tag, ":parity_err"}, pe_cyc, exp_pe);
        chk({tag, ":valid"}, valid, m_valid);
        chk({tag, ":data"}, data, m_data);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 50);

        // reset state
        chk("rst_pulses", {29'd0, fe, ov, pe}, 32'd0);
        check_state("reset");

        // single clean frame, consumer ready
        v_cyc = 0;
        do_frame(8'h55, 1'b0, 1'b1);
        check_state("f55");
        chk("f55_valid_cycles", v_cyc, 1);

        // short low pulse is rejected as a glitch
        send_glitch(100);
        check_state("glitch");

        // stop bit low -> frame error, then recovery
        do_frame(8'hA3, 1'b0, 1'b0);
        check_state("ferr_a3");
        do_frame(8'h3C, 1'b0, 1'b1);
        check_state("f3c");

        // consumer stalled: hold first byte, overrun on the second
        set_ready(1'b0);
        do_frame(8'h11, 1'b0, 1'b1);
        check_state("hold11");
        do_frame(8'h22, 1'b0, 1'b1);
        check_state("ovr22");
        set_ready(1'b1);
        check_state("drain");

        // reset in the middle of the data bits of 0xFF (line high there)
        drive(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive(1'b1, BIT);
        drive(1'b1, 200);
        rst_n = 1'b0;
        drive(1'b1, 1);
        rst_n = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        drive(1'b1, 6 * BIT);
        check_state("rst_mid");
        do_frame(8'h0F, 1'b0, 1'b1);
        check_state("f0f");

`ifdef UART_RX_PARITY_EN
        do_frame(8'h07, 1'b1, 1'b1);   // parity bit 0: odd total
        check_state("par_bad");
        do_frame(8'h07, 1'b0, 1'b1);   // parity bit 1: even total
        check_state("par_ok");
`endif

        // randomized frames, errors and consumer stalls
        for (int k = 0; k < 7; k++) begin
            int kind;
            bit bad_par;
            kind    = $urandom_range(0, 5);
            bad_par = PAR_EN ? bit'($urandom_range(0, 1)) : 1'b0;
            set_ready($urandom_range(0, 2) != 0);
            if (kind == 0) begin
                send_glitch($urandom_range(30, 150));
            end else begin
                do_frame(8'($urandom), bad_par, kind != 1);
            end
            check_state("rand");
        end
        set_ready(1'b1);
        check_state("final");
        chk("data_stable", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
